adder_multicycle: RTL and testbench
===================================

# adder_multicycle

Parametrised multi-cycle adder/subtractor: the successor to the fixed 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands one SLICE-bit slice per clock, LSB slice first. A registered carry links the slices, so carry logic stays SLICE bits deep at any WIDTH. It sits between a valid/ready producer and consumer in datapaths where area matters more than throughput.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle; 1 ≤ SLICE ≤ WIDTH. N = WIDTH/SLICE is the slice count.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- inValid  input  1  upstream offers an operation.
- outReady  output  1  block can accept; high only in IDLE.
- inA  input  WIDTH  operand A.
- inB  input  WIDTH  operand B.
- inCarry  input  1  carry-in in add mode; borrow-in in subtract mode.
- inSub  input  1  0 = add, 1 = subtract.
- outValid  output  1  result is available.
- inReady  input  1  downstream accepts the result.
- outSum  output  WIDTH  result.
- outCarry  output  1  carry-out. In subtract mode 1 means no borrow.
- outOverflow  output  1  signed overflow. Driven only when the overflow feature is compiled in (see Configuration).

## Operation
- The FSM has three states: IDLE, RUN and DONE. outReady = (state == IDLE).
- IDLE → RUN on an edge with inValid & outReady. On that edge the block captures inA, inB, inSub and inCarry and clears the slice index to 0.
- Effective operand B is inB in add mode and ~inB in subtract mode.
- The carry register is loaded with inCarry in add mode and with ~inCarry in subtract mode. Subtract mode therefore computes A − B − inCarry.
- In RUN, each edge processes slice k (bits [k·SLICE +: SLICE]):
  - sum slice = A slice + effective-B slice + carry register;
  - the low SLICE bits are written into the result register at slice k;
  - the slice carry-out is written back into the carry register;
  - k increments.
- The edge that processes slice N−1 moves the FSM RUN → DONE and asserts outValid.
- In DONE, outSum, outCarry and outOverflow are the registered result and stay stable until the handshake completes.
- DONE → IDLE on an edge with outValid & inReady; outValid drops on that same edge.
- inValid is ignored outside IDLE. Operand input changes after the accept edge have no effect.
- All arithmetic is modulo 2^WIDTH. outCarry is the carry out of bit WIDTH−1.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, outValid 0, outReady 1, outSum 0, outCarry 0, outOverflow 0, slice index 0.
- Latency: outValid rises exactly N cycles after the accept edge.
- Minimum initiation interval is N+2 cycles, made up of:
  - 1 accept cycle;
  - N RUN cycles;
  - 1 cycle for the handshake and return to IDLE.
- With inReady held high in DONE, outValid is high for exactly one cycle.
- With inReady low, the block stays in DONE indefinitely and holds its outputs.
- When SLICE == WIDTH (N = 1), the block completes in a single RUN cycle.
- Reset asserted mid-RUN or in DONE aborts the operation with no output. The block resumes from the reset values.

## Configuration
- ADDER_OVERFLOW_EN defined: outOverflow = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - It is computed during slice N−1 and registered with the result.
  - It is valid in both modes.
- ADDER_OVERFLOW_EN undefined: outOverflow is tied to 0 and no overflow logic is synthesised. The port list is unchanged.

## Test plan
All scenarios use WIDTH=16, SLICE=4 and ADDER_OVERFLOW_EN defined.
- Add wrap: inA=0xFFFF, inB=0x0001, inCarry=0, inSub=0 → outSum=0x0000, outCarry=1, outOverflow=0; outValid exactly 4 cycles after accept.
- Signed overflow: inA=0x7FFF, inB=0x0001, inCarry=0, inSub=0 → outSum=0x8000, outCarry=0, outOverflow=1.
- Subtract with borrow: inA=0x0005, inB=0x0007, inSub=1, inCarry=0 → outSum=0xFFFE, outCarry=0, outOverflow=0. Same operands with inCarry=1 → outSum=0xFFFD.
- Backpressure: hold inReady low for 3 cycles in DONE → outValid stays high, outSum stays stable, outReady stays low, and a toggling inValid with new operands is ignored. Raising inReady → outValid low next cycle and outReady high.
- Reset mid-operation: pull rst_n low after slice 2 of 0x1234+0x1111 → all outputs return to reset values immediately. A subsequent 0x1234+0x1111 yields 0x2345, outCarry=0.
- Back-to-back: two queued operations with inReady held high → second accept occurs 6 cycles after the first, and both results are correct.

Source files
------------

// File: rtl/adder_multicycle.sv
// Multi-cycle adder/subtractor: one SLICE-bit slice per clock, LSB first, with a registered inter-slice carry.
// Optional signed-overflow output is compiled in when ADDER_OVERFLOW_EN is defined.
module adder_multicycle #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             outReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inCarry,
  input  logic             inSub,
  output logic             outValid,
  input  logic             inReady,
  output logic [WIDTH-1:0] outSum,
  output logic             outCarry,
  output logic             outOverflow
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  // Slice adder: operands are shifted right each RUN cycle so the active slice is always at the bottom.
  logic [SLICE:0]   slice_ext_c;
  logic [SLICE-1:0] slice_sum_c;
  logic             slice_cout_c;

  assign slice_ext_c  = (SLICE+1)'(a_q[SLICE-1:0]) + (SLICE+1)'(b_q[SLICE-1:0]) + (SLICE+1)'(carry_q);
  assign slice_sum_c  = slice_ext_c[SLICE-1:0];
  assign slice_cout_c = slice_ext_c[SLICE];

`ifdef ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic slice_cin_msb_c;
  logic slice_ovf_c;

  // Carry into the slice MSB recovered from the MSB sum bit; only meaningful on the last slice.
  assign slice_cin_msb_c = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_sum_c[SLICE-1];
  assign slice_ovf_c     = slice_cin_msb_c ^ slice_cout_c;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (inValid) begin
          state_d = RUN;
          a_d     = inA;
          b_d     = inSub ? ~inB : inB;
          carry_d = inCarry ^ inSub;
          idx_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = slice_cout_c;
        sum_d   = (sum_q >> SLICE) | (WIDTH'(slice_sum_c) << (WIDTH - SLICE));
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = slice_cout_c;
`ifdef ADDER_OVERFLOW_EN
          ovf_d   = slice_ovf_c;
`endif
        end
      end
      DONE: begin
        if (inReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

`ifdef ADDER_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign outOverflow = ovf_q;
`else
  assign outOverflow = 1'b0;
`endif

  assign outReady = ready_q;
  assign outValid = valid_q;
  assign outSum   = sum_q;
  assign outCarry = cout_q;

endmodule

// File: tb/tb_adder_multicycle.sv
// Directed testbench for adder_multicycle (WIDTH=16, SLICE=4); overflow expectations apply when ADDER_OVERFLOW_EN is defined.
module tb_adder_multicycle;

`ifdef ADDER_OVERFLOW_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        outReady;
  logic [15:0] inA;
  logic [15:0] inB;
  logic        inCarry;
  logic        inSub;
  logic        outValid;
  logic        inReady;
  logic [15:0] outSum;
  logic        outCarry;
  logic        outOverflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  adder_multicycle #(.WIDTH(16), .SLICE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inValid     (inValid),
    .outReady    (outReady),
    .inA         (inA),
    .inB         (inB),
    .inCarry     (inCarry),
    .inSub       (inSub),
    .outValid    (outValid),
    .inReady     (inReady),
    .outSum      (outSum),
    .outCarry    (outCarry),
    .outOverflow (outOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ov;
  } vec_t;

  vec_t vecs[11];

  // Back-to-back monitor: records accept times and delivered results.
  bit          mon_on = 1'b0;
  int          acc_q[$];
  logic [15:0] res_q[$];
  logic        resc_q[$];

  always @(posedge clk) begin
    if (mon_on && inValid && outReady) acc_q.push_back(cyc_cnt);
    if (mon_on && outValid && inReady) begin
      res_q.push_back(outSum);
      resc_q.push_back(outCarry);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sub, input logic [15:0] s,
                              input logic c, input logic ov);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.sum = s; v.cout = c; v.ov = ov;
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int lat;
    int w;
    inA = v.a; inB = v.b; inCarry = v.cin; inSub = v.sub; inValid = 1'b1;
    w = 0;
    while (!outReady && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    inA = 16'($urandom);
    inB = 16'($urandom);
    inCarry = ~v.cin;
    inSub = ~v.sub;
    lat = 0;
    while (!outValid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'd4);
    check({v.name, " sum"}, 32'(outSum), 32'(v.sum));
    check({v.name, " carry"}, 32'(outCarry), 32'(v.cout));
    check({v.name, " overflow"}, 32'(outOverflow), 32'(OV_EN ? v.ov : 1'b0));
    inReady = 1'b1;
    @(posedge clk); #1;
    inReady = 1'b0;
    check({v.name, " valid drop"}, 32'(outValid), 32'd0);
    check({v.name, " ready back"}, 32'(outReady), 32'd1);
  endtask

  initial begin
    vecs[0]  = mk("add_wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[1]  = mk("add_sovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    vecs[2]  = mk("sub_b0",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    vecs[3]  = mk("sub_b1",       16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    vecs[4]  = mk("add_plain",    16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    vecs[5]  = mk("add_negovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vecs[6]  = mk("sub_minovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    vecs[7]  = mk("add_cin",      16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    vecs[8]  = mk("sub_equal",    16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    vecs[9]  = mk("add_all1_cin", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    vecs[10] = mk("sub_zero_b1",  16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    rst_n = 1'b0; inValid = 1'b0; inReady = 1'b0;
    inA = '0; inB = '0; inCarry = 1'b0; inSub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset outReady", 32'(outReady), 32'd1);
    check("reset outValid", 32'(outValid), 32'd0);
    check("reset outSum", 32'(outSum), 32'd0);
    check("reset outCarry", 32'(outCarry), 32'd0);
    check("reset outOverflow", 32'(outOverflow), 32'd0);

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // Backpressure: hold DONE for 3 cycles while new requests are offered.
    inA = 16'h1234; inB = 16'h1111; inCarry = 1'b0; inSub = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    begin
      int lat = 0;
      while (!outValid && lat < 20) begin
        @(posedge clk); #1; lat++;
      end
      check("bp latency", 32'(lat), 32'd4);
    end
    for (int k = 0; k < 3; k++) begin
      inValid = ~inValid;
      inA = 16'hA5A5 + 16'(k); inB = 16'h0F0F; inSub = 1'b1;
      @(posedge clk); #1;
      check("bp outValid held", 32'(outValid), 32'd1);
      check("bp outSum held", 32'(outSum), 32'h2345);
      check("bp outReady low", 32'(outReady), 32'd0);
    end
    inValid = 1'b0;
    inReady = 1'b1;
    @(posedge clk); #1;
    inReady = 1'b0;
    check("bp release outValid", 32'(outValid), 32'd0);
    check("bp release outReady", 32'(outReady), 32'd1);

    // Reset in the middle of RUN after three slices.
    inA = 16'h1234; inB = 16'h1111; inCarry = 1'b0; inSub = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst outValid", 32'(outValid), 32'd0);
    check("midrst outReady", 32'(outReady), 32'd1);
    check("midrst outSum", 32'(outSum), 32'd0);
    check("midrst outCarry", 32'(outCarry), 32'd0);
    check("midrst outOverflow", 32'(outOverflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(mk("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0));

    // Back-to-back: two queued operations with inReady high.
    mon_on = 1'b1;
    inReady = 1'b1;
    inA = 16'h1234; inB = 16'h1111; inCarry = 1'b0; inSub = 1'b0; inValid = 1'b1;
    begin
      int w = 0;
      while (acc_q.size() < 1 && w < 30) begin
        @(posedge clk); #1; w++;
      end
      inA = 16'h0005; inB = 16'h0007; inCarry = 1'b0; inSub = 1'b1;
      w = 0;
      while (acc_q.size() < 2 && w < 30) begin
        @(posedge clk); #1; w++;
      end
      inValid = 1'b0;
      w = 0;
      while (res_q.size() < 2 && w < 30) begin
        @(posedge clk); #1; w++;
      end
    end
    mon_on = 1'b0;
    inReady = 1'b0;
    check("b2b accept count", 32'(acc_q.size()), 32'd2);
    check("b2b result count", 32'(res_q.size()), 32'd2);
    if (acc_q.size() == 2) check("b2b initiation interval", 32'(acc_q[1] - acc_q[0]), 32'd6);
    if (res_q.size() == 2) begin
      check("b2b sum0", 32'(res_q[0]), 32'h2345);
      check("b2b carry0", 32'(resc_q[0]), 32'd0);
      check("b2b sum1", 32'(res_q[1]), 32'hFFFE);
      check("b2b carry1", 32'(resc_q[1]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
